// File: rtl/type_rule_cfg_writer.sv
// Assembles configuration word streams into packed type rules and issues
// one-hot (or per-stage clear) write strobes to the parser's lookup tables.
module type_rule_cfg_writer #(
  parameter int STAGE_NUM  = 4,
  parameter int RULE_NUM   = 8,
  parameter int RULE_WIDTH = 72,
  parameter int CFG_WIDTH  = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_cfg_valid,
  input  logic [CFG_WIDTH-1:0]          i_cfg_data,
  input  logic                          i_cfg_last,
  output logic                          o_cfg_ready,
  output logic [STAGE_NUM*RULE_NUM-1:0] o_rule_wren,
  output logic [RULE_WIDTH-1:0]         o_type_rule,
  output logic                          o_cfg_done,
  output logic                          o_cfg_err,
  output logic [15:0]                   o_wr_cnt
);

  localparam int BEAT_NUM = (RULE_WIDTH + CFG_WIDTH - 1) / CFG_WIDTH;
  localparam int BCW      = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
  localparam int WREN_W   = STAGE_NUM * RULE_NUM;
  localparam logic [WREN_W-1:0] ONE_SLOT  = WREN_W'(1);
  localparam logic [WREN_W-1:0] ALL_SLOTS = WREN_W'({RULE_NUM{1'b1}});

  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, WRITE, ERR} state_t;

  state_t                  state, state_n;
  logic [BCW-1:0]          beat_cnt, beat_n;
  logic [RULE_WIDTH-1:0]   rule_buf, rule_buf_n;
  logic [7:0]              stage_q, stage_n, idx_q, idx_n;
  logic                    clr_q, clr_n;
  logic [WREN_W-1:0]       wren_n;
  logic                    xfer;
  logic                    good_wr, good_clr;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign xfer     = i_cfg_valid && o_cfg_ready;
  assign good_wr  = (i_cfg_data[31:24] == 8'h01) && (int'(i_cfg_data[23:16]) < STAGE_NUM)
                    && (int'(i_cfg_data[15:8]) < RULE_NUM);
  assign good_clr = (i_cfg_data[31:24] == 8'h02) && (int'(i_cfg_data[23:16]) < STAGE_NUM);

  always_comb begin
    state_n    = state;
    beat_n     = beat_cnt;
    rule_buf_n = rule_buf;
    stage_n    = stage_q;
    idx_n      = idx_q;
    clr_n      = clr_q;
    wren_n     = '0;
    case (state)
      IDLE: begin
        if (xfer) begin
          stage_n = i_cfg_data[23:16];
          idx_n   = i_cfg_data[15:8];
          clr_n   = (i_cfg_data[31:24] == 8'h02);
          beat_n  = '0;
          if (good_wr && !i_cfg_last)      state_n = COLLECT;
          else if (good_clr && i_cfg_last) state_n = WRITE;
          else if (i_cfg_last)             state_n = ERR;
          else                             state_n = DRAIN;
        end
      end
      COLLECT: begin
        if (xfer) begin
          // Final-beat bits beyond the rule width are simply dropped.
          for (int b = 0; b < CFG_WIDTH; b++) begin
            if (int'(beat_cnt) * CFG_WIDTH + b < RULE_WIDTH)
              rule_buf_n[int'(beat_cnt) * CFG_WIDTH + b] = i_cfg_data[b];
          end
          if (int'(beat_cnt) == BEAT_NUM - 1) state_n = i_cfg_last ? WRITE : DRAIN;
          else if (i_cfg_last)                state_n = ERR;
          else                                beat_n  = beat_cnt + BCW'(1);
        end
      end
      DRAIN: begin
        if (xfer && i_cfg_last) state_n = ERR;
      end
      WRITE:   state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (state_n == WRITE) begin
      if (clr_n) wren_n = ALL_SLOTS << (int'(stage_n) * RULE_NUM);
      else       wren_n = ONE_SLOT << (int'(stage_n) * RULE_NUM + int'(idx_n));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      rule_buf    <= '0;
      stage_q     <= '0;
      idx_q       <= '0;
      clr_q       <= 1'b0;
      o_cfg_ready <= 1'b1;
      o_rule_wren <= '0;
      o_type_rule <= '0;
      o_cfg_done  <= 1'b0;
      o_cfg_err   <= 1'b0;
      o_wr_cnt    <= '0;
    end else begin
      state       <= state_n;
      beat_cnt    <= beat_n;
      rule_buf    <= rule_buf_n;
      stage_q     <= stage_n;
      idx_q       <= idx_n;
      clr_q       <= clr_n;
      // Outputs are decided one cycle ahead so they land exactly on WRITE/ERR.
      o_cfg_ready <= (state_n != WRITE) && (state_n != ERR);
      o_rule_wren <= wren_n;
      o_cfg_done  <= (state_n == WRITE);
      o_cfg_err   <= (state_n == ERR);
      if (state_n == WRITE) begin
        o_type_rule <= clr_n ? '0 : rule_buf_n;
        o_wr_cnt    <= sat_add16(o_wr_cnt, clr_n ? 16'(RULE_NUM) : 16'd1);
      end
    end
  end

endmodule

// File: tb/tb_type_rule_cfg_writer.sv
// Directed scoreboard bench for type_rule_cfg_writer: stimulus pushes expected
// completions, a monitor pops and compares whenever done/err/wren appear.
module tb_type_rule_cfg_writer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic [31:0] i_cfg_data = '0;
  logic        i_cfg_last = 1'b0;
  logic        o_cfg_ready;
  logic [31:0] o_rule_wren;
  logic [71:0] o_type_rule;
  logic        o_cfg_done;
  logic        o_cfg_err;
  logic [15:0] o_wr_cnt;

  type_rule_cfg_writer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cfg_valid(i_cfg_valid), .i_cfg_data(i_cfg_data), .i_cfg_last(i_cfg_last),
    .o_cfg_ready(o_cfg_ready), .o_rule_wren(o_rule_wren), .o_type_rule(o_type_rule),
    .o_cfg_done(o_cfg_done), .o_cfg_err(o_cfg_err), .o_wr_cnt(o_wr_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          is_err;
    logic [31:0] wren;
    logic [71:0] rule;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 16'hFFFF) ? 16'hFFFF : 16'(v);
  endfunction

  // Monitor: every cycle either a completion/error pulse is presented or ready must be high.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_rule_wren != '0 || o_cfg_done || o_cfg_err) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: wren=%0h done=%0b err=%0b with empty scoreboard",
                   o_rule_wren, o_cfg_done, o_cfg_err);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("err_pulse", 128'(o_cfg_err), 128'(e.is_err));
          chk("done_pulse", 128'(o_cfg_done), 128'(!e.is_err));
          chk("wren", 128'(o_rule_wren), 128'(e.wren));
          chk("wr_cnt", 128'(o_wr_cnt), 128'(e.cnt));
          chk("ready_low", 128'(o_cfg_ready), 128'(0));
          if (!e.is_err) chk("type_rule", 128'(o_type_rule), 128'(e.rule));
        end
      end else begin
        chk("ready_idle", 128'(o_cfg_ready), 128'(1));
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit last, input int max_gap);
    int n;
    repeat ($urandom_range(max_gap, 0)) @(posedge i_clk);
    #1;
    i_cfg_valid = 1'b1; i_cfg_data = d; i_cfg_last = last;
    n = 0;
    do begin
      @(posedge i_clk);
      n++;
    end while (!o_cfg_ready && n < 50);
    if (!o_cfg_ready) begin
      errors++; checks++;
      $display("FAIL handshake_timeout: ready stayed 0 for data %0h", d);
    end
    #1;
    i_cfg_valid = 1'b0; i_cfg_last = 1'b0;
  endtask

  task automatic push_done(input logic [31:0] wren, input logic [71:0] rule, input int inc);
    exp_t e;
    exp_cnt = sat16(int'(exp_cnt) + inc);
    e.is_err = 1'b0; e.wren = wren; e.rule = rule; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.wren = '0; e.rule = '0; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  task automatic do_write(input int st, input int ix, input logic [31:0] d0, d1, d2,
                          input logic [71:0] rule, input int gap);
    push_done(32'(1) << (st * 8 + ix), rule, 1);
    send({8'h01, 8'(st), 8'(ix), 8'h00}, 1'b0, gap);
    send(d0, 1'b0, gap);
    send(d1, 1'b0, gap);
    send(d2, 1'b1, gap);
  endtask

  task automatic do_clear(input int st, input logic [31:0] wren, input int gap);
    push_done(wren, '0, 8);
    send({8'h02, 8'(st), 16'h0000}, 1'b1, gap);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge i_clk);
      n++;
    end
    @(posedge i_clk);
    chk("scoreboard_drained", 128'(q.size()), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", 128'(o_cfg_ready), 128'(1));
    chk("rst_wren", 128'(o_rule_wren), 128'(0));
    chk("rst_rule", 128'(o_type_rule), 128'(0));
    chk("rst_done_err", 128'({o_cfg_done, o_cfg_err}), 128'(0));
    chk("rst_cnt", 128'(o_wr_cnt), 128'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;

    do_write(1, 3, 32'h11111111, 32'h22222222, 32'h000000C3, 72'hC3_22222222_11111111, 0);
    do_clear(2, 32'h00FF_0000, 0);
    // Bad stage id: drained then rejected
    push_err();
    send(32'h01070000, 1'b0, 1);
    send(32'hDEAD0001, 1'b0, 1);
    send(32'hDEAD0002, 1'b0, 1);
    send(32'hDEAD0003, 1'b1, 1);
    // Early last
    push_err();
    send(32'h01000000, 1'b0, 0);
    send(32'h12345678, 1'b1, 0);
    do_write(0, 5, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 72'hFF_55555555_AAAAAAAA, 0);
    // Overlong
    push_err();
    send(32'h01000000, 1'b0, 2);
    for (int i = 0; i < 4; i++) send(32'h0BAD0000 + 32'(i), (i == 3), 2);
    // Back-to-back with random gaps
    do_write(0, 0, 32'h01020304, 32'h05060708, 32'h0000009A, 72'h9A_05060708_01020304, 3);
    do_write(0, 7, 32'hCAFEF00D, 32'h0F0F0F0F, 32'h00000077, 72'h77_0F0F0F0F_CAFEF00D, 3);
    // Unknown opcode with last
    push_err();
    send(32'h7F000000, 1'b1, 0);
    wait_drain();

    // Reset mid-write after beat 2
    send(32'h01030200, 1'b0, 0);
    send(32'h11112222, 1'b0, 0);
    send(32'h33334444, 1'b0, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_ready", 128'(o_cfg_ready), 128'(1));
    chk("midrst_wren", 128'(o_rule_wren), 128'(0));
    chk("midrst_cnt", 128'(o_wr_cnt), 128'(0));
    chk("midrst_rule", 128'(o_type_rule), 128'(0));
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_cnt = '0;

    // Saturation: 8191 clears reach 0xFFF8, four writes reach 0xFFFC
    for (int i = 0; i < 8191; i++) do_clear(i % 4, 32'h0000_00FF << ((i % 4) * 8), 0);
    for (int i = 0; i < 4; i++)
      do_write(3, i, 32'h0 + 32'(i), 32'h0, 32'h80, 72'h80_00000000_00000000 | 72'(i), 0);
    do_clear(1, 32'h0000_FF00, 0);
    do_clear(3, 32'hFF00_0000, 0);
    wait_drain();
    #1;
    chk("sat_cnt_final", 128'(o_wr_cnt), 128'(16'hFFFF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
